// File: rtl/npn_pkg.sv
// Shared constants, FSM state type and permutation helpers for the NPN canonicaliser.
// perm_of() decodes a Lehmer-code index into an ordered list of input positions.
package npn_pkg;

    localparam int N_MAX = 5;
    localparam int IDX_W = 3;

    typedef logic [N_MAX-1:0][IDX_W-1:0] perm_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    function automatic int fact(input int n);
        int r;
        r = 1;
        for (int i = 2; i <= n; i++) r = r * i;
        return r;
    endfunction

    // Entries at and above n are left zero; perm_of(0, n) is the identity.
    function automatic perm_t perm_of(input int k, input int n);
        perm_t p;
        perm_t avail;
        int    rem;
        int    f;
        int    d;
        p   = '0;
        rem = k;
        for (int i = 0; i < N_MAX; i++) avail[i] = IDX_W'(i);
        for (int i = 0; i < N_MAX; i++) begin
            if (i < n) begin
                f   = fact(n - 1 - i);
                d   = rem / f;
                rem = rem % f;
                for (int t = 0; t < N_MAX; t++) if (t == d) p[i] = avail[t];
                for (int t = 0; t < N_MAX - 1; t++) if (t >= d) avail[t] = avail[t + 1];
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/npn_apply.sv
// Combinational NPN transform with positive output polarity:
// result bit j = tt[idx], idx bit i = j[perm[i]] ^ neg[i].
module npn_apply
    import npn_pkg::*;
#(
    parameter  int N    = 4,
    localparam int TT_W = 2 ** N
) (
    input  logic [TT_W-1:0] i_tt,
    input  perm_t           i_perm,
    input  logic [N-1:0]    i_neg,
    output logic [TT_W-1:0] o_tt
);

    // Minterm index widened so any 3-bit permutation entry selects in range.
    logic [(1 << IDX_W)-1:0] w_j;
    logic [N-1:0]            w_idx;

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        o_tt  = '0;
        w_j   = '0;
        w_idx = '0;
        for (int j = 0; j < TT_W; j++) begin
            w_j = (1 << IDX_W)'(j);
            for (int i = 0; i < N; i++) w_idx[i] = w_j[i_perm[i]] ^ i_neg[i];
            o_tt[j] = i_tt[w_idx];
        end
    end

endmodule

// File: rtl/npn_canon_engine.sv
// Sequential NPN canonicaliser: sweeps every (permutation, negation mask) pair one per
// cycle, both output polarities each, and reports the smallest table with its transform.
module npn_canon_engine
    import npn_pkg::*;
#(
    parameter  int N      = 4,
    localparam int TT_W   = 2 ** N,
    localparam int PERM_W = $clog2(fact(N))
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [TT_W-1:0]   in_tt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [TT_W-1:0]   out_tt,
    output logic [PERM_W-1:0] out_perm,
    output logic [N-1:0]      out_neg,
    output logic              out_onot
);

    localparam int FACT_N = fact(N);

    state_t            r_state;
    logic [TT_W-1:0]   r_tt;
    logic [PERM_W-1:0] r_k;
    logic [N-1:0]      r_m;
    logic              r_first;
    logic [TT_W-1:0]   r_best_tt;
    logic [PERM_W-1:0] r_best_perm;
    logic [N-1:0]      r_best_neg;
    logic              r_best_onot;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [TT_W-1:0]   r_out_tt;
    logic [PERM_W-1:0] r_out_perm;
    logic [N-1:0]      r_out_neg;
    logic              r_out_onot;

    perm_t           w_perm_rom [FACT_N];
    perm_t           w_perm;
    logic [TT_W-1:0] w_c;
    logic [TT_W-1:0] w_nc;
    logic [TT_W-1:0] w_pick;
    logic            w_onot;
    logic            w_take;
    logic            w_last;

    // Permutation table is folded to constants at elaboration time.
    for (genvar g = 0; g < FACT_N; g++) begin : g_perm_rom
        assign w_perm_rom[g] = perm_of(g, N);
    end

    assign w_perm = w_perm_rom[r_k];

    npn_apply #(.N(N)) u_apply (
        .i_tt   (r_tt),
        .i_perm (w_perm),
        .i_neg  (r_m),
        .o_tt   (w_c)
    );

    // c and ~c differ in every bit, so they never tie.
    assign w_nc   = ~w_c;
    assign w_onot = (w_nc < w_c);
    assign w_pick = w_onot ? w_nc : w_c;
    assign w_take = r_first || (w_pick < r_best_tt);
    assign w_last = (r_k == PERM_W'(FACT_N - 1)) && (&r_m);

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_tt        <= '0;
            r_k         <= '0;
            r_m         <= '0;
            r_first     <= 1'b0;
            r_best_tt   <= '0;
            r_best_perm <= '0;
            r_best_neg  <= '0;
            r_best_onot <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_tt    <= '0;
            r_out_perm  <= '0;
            r_out_neg   <= '0;
            r_out_onot  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_tt       <= in_tt;
                        r_k        <= '0;
                        r_m        <= '0;
                        r_first    <= 1'b1;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_first <= 1'b0;
                    if (w_take) begin
                        r_best_tt   <= w_pick;
                        r_best_perm <= r_k;
                        r_best_neg  <= r_m;
                        r_best_onot <= w_onot;
                    end
                    // Outputs only change here, so they hold through DONE and the next IDLE.
                    if (w_last) begin
                        r_out_tt    <= w_take ? w_pick : r_best_tt;
                        r_out_perm  <= w_take ? r_k    : r_best_perm;
                        r_out_neg   <= w_take ? r_m    : r_best_neg;
                        r_out_onot  <= w_take ? w_onot : r_best_onot;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else if (&r_m) begin
                        r_m <= '0;
                        r_k <= r_k + 1'b1;
                    end else begin
                        r_m <= r_m + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_tt    = r_out_tt;
    assign out_perm  = r_out_perm;
    assign out_neg   = r_out_neg;
    assign out_onot  = r_out_onot;

endmodule
